int_to_float_pipe: RTL and testbench
====================================

# int_to_float_pipe

Parametrised, pipelined integer/fixed-point to IEEE-754 binary32 converter for the encoder's DCT/quantisation datapath. It accepts a WIDTH-bit two's-complement or unsigned sample, selected per sample, with a compile-time binary-point position. It produces a correctly rounded (round-to-nearest-even) float32 through a 3-stage pipeline. Both ends use valid/ready handshakes with full backpressure, so it drops between any producer and the float arithmetic units.

## Interface
- WIDTH, 8: input sample width in bits; legal range 2..32.
- FRAC_BITS, 0: number of fractional bits in the input, 0..WIDTH; output equals din / 2^FRAC_BITS.
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  reset; synchronous, active-high.
- din  in  WIDTH  input sample.
- din_signed  in  1  1: din is two's complement; 0: din is unsigned; sampled with din.
- din_valid  in  1  input sample present.
- din_ready  out  1  block accepts din this cycle.
- dout  out  32  float32 result {sign, exp[7:0], man[22:0]}.
- dout_valid  out  1  dout holds a result.
- dout_ready  in  1  consumer accepts dout this cycle.

## Operation
- Transfer in when din_valid && din_ready. Transfer out when dout_valid && dout_ready.
- Stage 1 (S1): capture sign = din_signed & din[WIDTH-1]. Compute abs = sign ? -din : din, held in WIDTH bits unsigned. The most negative input (e.g. -128 at WIDTH=8) gives abs = 2^(WIDTH-1) exactly.
- Stage 2 (S2):
  - lnz = leading-zero count of abs.
  - Normalise: norm = abs << lnz, so the MSB is the hidden 1.
  - exp = 127 + (WIDTH-1-lnz) - FRAC_BITS, computed in 9 bits.
  - Flag zero = (abs == 0).
- Stage 3 (S3), round and pack:
  - Take 23 mantissa bits below the hidden bit. Guard = next bit; sticky = OR of all remaining bits (zero when WIDTH <= 24).
  - Round up iff guard && (sticky || mantissa LSB).
  - A mantissa carry-out clears the mantissa and increments exp.
  - zero forces dout = 32'h0000_0000 (+0.0, never -0.0).
- Range: with WIDTH <= 32 and FRAC_BITS <= WIDTH, exp is always 95..159 after rounding. No denormals, infinities or NaNs can occur, so there is no overflow/underflow logic.

## Timing
- Latency: 3 cycles from input transfer to dout_valid, with no stalls. Throughput: 1 sample/cycle.
- Each stage has a valid bit v1..v3; v3 drives dout_valid.
- Stage k loads when it is empty or the stage after it advances:
  - en3 = ~v3 | dout_ready
  - en2 = ~v2 | en3
  - en1 = ~v1 | en2
  - din_ready = en1
- Bubbles collapse. The combinational path dout_ready -> din_ready is permitted.
- A stalled stage holds its data and valid unchanged. dout is stable while dout_valid && ~dout_ready.
- Reset: v1..v3 = 0, dout_valid = 0, dout = 0, and din_ready = 1 in the first cycle after reset.
- Reset mid-operation discards all in-flight samples. No output is produced for them, and rst overrides any simultaneous transfer.
- din_valid with din_ready low: no transfer. The producer holds din and din_signed until accepted.
- Simultaneous input and output transfer with a full pipeline is legal and sustains full rate.

## Structure
- Package int_to_float_pkg holds:
  - FP32_EXP_BIAS = 127, FP32_MAN_W = 23, FP32_EXP_W = 8.
  - typedef fp32_t: packed struct {sign, exp[7:0], man[22:0]}.
  - Stage-register struct typedefs s1_t and s2_t.
- Sub-module: lead_nz (WIDTH = WIDTH, output $clog2(WIDTH)+1 bits), instantiated in S2.
- Stage datapaths are always_comb blocks feeding enable-gated always_ff registers. Valid bits are registered with synchronous rst.

## Test plan
- WIDTH=8, FRAC_BITS=0, signed; din = 8'h01, 8'h80 (-128), 8'hFF (-1), 8'h00 -> 32'h3F80_0000, 32'hC300_0000, 32'hBF80_0000, 32'h0000_0000 in order, each 3 cycles after input.
- WIDTH=8, unsigned; din = 8'hFF -> 32'h437F_0000 (255.0). WIDTH=8, FRAC_BITS=4, signed; din = 8'h18 -> 32'h3FC0_0000 (1.5).
- WIDTH=32, unsigned rounding cases:
  - 16777217 -> 32'h4B80_0000 (tie to even).
  - 16777219 -> 32'h4B80_0002 (tie to even, rounds up).
  - 32'hFFFF_FFFF -> 32'h4F80_0000 (carry into exponent).
- Backpressure: stream 10 samples with dout_ready toggling 1/0 every cycle and din_valid random. Required:
  - every output matches the model, in order, with none lost or duplicated;
  - dout stable while stalled;
  - with dout_ready held 0, din_ready falls after exactly 3 accepted samples.
- Full-rate: din_valid and dout_ready held 1 for 100 cycles -> 100 results, one per cycle after 3-cycle fill.
- Reset mid-stream: assert rst with 3 samples in flight -> dout_valid = 0 and dout = 0 next cycle, and no stale result appears after rst deasserts.

Source files
------------

// File: rtl/int_to_float_pkg.sv
// Shared types and constants for the integer/fixed-point to float32 pipeline.
// Stage records are sized for the widest legal sample so the package stays unparameterised.
package int_to_float_pkg;

  localparam int FP32_EXP_BIAS = 127;
  localparam int FP32_MAN_W    = 23;
  localparam int FP32_EXP_W    = 8;
  localparam int MAX_W         = 32;

  typedef struct packed {
    logic                  sign;
    logic [FP32_EXP_W-1:0] exp;
    logic [FP32_MAN_W-1:0] man;
  } fp32_t;

  // Magnitude is right-aligned; only the low WIDTH bits are ever non-zero.
  typedef struct packed {
    logic             sign;
    logic [MAX_W-1:0] mag;
  } s1_t;

  // Normalised magnitude is left-aligned so the hidden 1 always sits at bit MAX_W-1.
  typedef struct packed {
    logic             sign;
    logic             zero;
    logic [8:0]       exp;
    logic [MAX_W-1:0] norm;
  } s2_t;

endpackage

// File: rtl/int_to_float_if.sv
// Valid/ready bundle for the converter: sample in on one side, float32 out on the other.
interface int_to_float_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] din;
  logic             din_signed;
  logic             din_valid;
  logic             din_ready;
  logic [31:0]      dout;
  logic             dout_valid;
  logic             dout_ready;

  modport master (
    output din, din_signed, din_valid, dout_ready,
    input  din_ready, dout, dout_valid
  );

  modport slave (
    input  din, din_signed, din_valid, dout_ready,
    output din_ready, dout, dout_valid
  );

endinterface

// File: rtl/int_to_float_pipe_lead_nz.sv
// Leading-zero counter; an all-zero input reports WIDTH.
module lead_nz #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] val,
  output logic [CNT_W-1:0] count
);

  // Scanning upward lets the highest set bit overwrite any lower hit.
  always_comb begin
    count = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (val[i]) count = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/int_to_float_pipe.sv
// Three-stage integer/fixed-point to float32 converter (round-to-nearest-even)
// with valid/ready backpressure on both sides.
module int_to_float_pipe
  import int_to_float_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int FRAC_BITS = 0
) (
  input  logic           clk,
  input  logic           rst,
  int_to_float_if.slave  bus
);

  localparam int         CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [8:0] EXP_BASE = 9'(FP32_EXP_BIAS + WIDTH - 1 - FRAC_BITS);

  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic en1, en2, en3;
  logic ld1, ld2, ld3;

  s1_t   s1_q, s1_d;
  s2_t   s2_q, s2_d;
  fp32_t dout_q, dout_d;

  logic [WIDTH-1:0]      din_abs;
  logic                  din_neg;
  logic [CNT_W-1:0]      lnz;
  logic [FP32_MAN_W:0]   man_sum;
  logic                  guard, sticky, round_up;
  logic                  unused_bits;

  // A stage advances when it is empty or its successor is advancing.
  always_comb begin
    en3  = ~v3_q | bus.dout_ready;
    en2  = ~v2_q | en3;
    en1  = ~v1_q | en2;
    ld1  = en1 & bus.din_valid;
    ld2  = en2 & v1_q;
    ld3  = en3 & v2_q;
    v1_d = en1 ? bus.din_valid : v1_q;
    v2_d = en2 ? v1_q : v2_q;
    v3_d = en3 ? v2_q : v3_q;
  end

  assign bus.din_ready  = en1;
  assign bus.dout_valid = v3_q;
  assign bus.dout       = dout_q;

  always_comb begin
    din_neg     = bus.din_signed & bus.din[WIDTH-1];
    din_abs     = din_neg ? -bus.din : bus.din;
    s1_d.sign   = din_neg;
    s1_d.mag    = MAX_W'(din_abs);
  end

  lead_nz #(
    .WIDTH (WIDTH)
  ) u_lead_nz (
    .val   (s1_q.mag[WIDTH-1:0]),
    .count (lnz)
  );

  always_comb begin
    s2_d.sign = s1_q.sign;
    s2_d.zero = (s1_q.mag == '0);
    s2_d.exp  = EXP_BASE - 9'(lnz);
    s2_d.norm = (s1_q.mag << (MAX_W - WIDTH)) << lnz;
  end

  // Bit 31 is the hidden 1, bits 30:8 the mantissa, bit 7 the guard.
  always_comb begin
    guard       = s2_q.norm[7];
    sticky      = |s2_q.norm[6:0];
    round_up    = guard & (sticky | s2_q.norm[8]);
    man_sum     = {1'b0, s2_q.norm[30:8]} + (FP32_MAN_W + 1)'(round_up);
    dout_d.sign = s2_q.sign;
    dout_d.exp  = s2_q.exp[7:0] + 8'(man_sum[FP32_MAN_W]);
    dout_d.man  = man_sum[FP32_MAN_W-1:0];
    if (s2_q.zero) dout_d = '0;
  end

  assign unused_bits = ^{s2_q.exp[8], s2_q.norm[31]};

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      s1_q   <= '0;
      s2_q   <= '0;
      dout_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      if (ld1) s1_q   <= s1_d;
      if (ld2) s2_q   <= s2_d;
      if (ld3) dout_q <= dout_d;
    end
  end

endmodule

// File: tb/tb_int_to_float_pipe.sv
// Bench for int_to_float_pipe: fixed vectors on three parameterisations plus
// randomised streaming against an arithmetic reference model.
module tb_int_to_float_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   act   = 0;

  logic [31:0] o_dout;
  logic        o_dv;
  logic        o_dr;

  always #5 clk = ~clk;

  int_to_float_if #(.WIDTH(8))  if_a ();
  int_to_float_if #(.WIDTH(8))  if_b ();
  int_to_float_if #(.WIDTH(32)) if_c ();

  int_to_float_pipe #(.WIDTH(8),  .FRAC_BITS(0)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  int_to_float_pipe #(.WIDTH(8),  .FRAC_BITS(4)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
  int_to_float_pipe #(.WIDTH(32), .FRAC_BITS(0)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

  always_comb begin
    o_dout = if_a.dout;
    o_dv   = if_a.dout_valid;
    o_dr   = if_a.din_ready;
    if (act == 1) begin
      o_dout = if_b.dout;
      o_dv   = if_b.dout_valid;
      o_dr   = if_b.din_ready;
    end else if (act == 2) begin
      o_dout = if_c.dout;
      o_dv   = if_c.dout_valid;
      o_dr   = if_c.din_ready;
    end
  end

  typedef struct {
    int          sel;
    logic [31:0] d;
    logic        s;
    logic [31:0] want;
    string       name;
  } vec_t;

  vec_t        vecs[10];
  logic [31:0] expq[$];

  // Reference: exact magnitude, find the top bit, round the discarded tail to nearest-even.
  function automatic logic [31:0] model(input logic [31:0] d, input logic s,
                                        input int w, input int frac);
    longint unsigned raw, mag, mant, rem, half;
    int              p, shift;
    logic            neg;
    logic [7:0]      e;
    raw = {32'b0, d} & ((64'd1 << w) - 64'd1);
    neg = s && raw[w-1];
    mag = neg ? ((64'd1 << w) - raw) : raw;
    if (mag == 0) return 32'h0;
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    if (p <= 23) begin
      mant = mag << (23 - p);
    end else begin
      shift = p - 23;
      mant  = mag >> shift;
      rem   = mag - (mant << shift);
      half  = 64'd1 << (shift - 1);
      if (rem > half || (rem == half && mant[0])) mant = mant + 1;
    end
    if (mant == (64'd1 << 24)) begin
      mant = mant >> 1;
      p++;
    end
    e = 8'(127 + p - frac);
    return {neg, e, mant[22:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic set_in(input logic [31:0] d, input logic s, input logic v, input logic r);
    case (act)
      0: begin if_a.din = d[7:0]; if_a.din_signed = s; if_a.din_valid = v; if_a.dout_ready = r; end
      1: begin if_b.din = d[7:0]; if_b.din_signed = s; if_b.din_valid = v; if_b.dout_ready = r; end
      default: begin if_c.din = d; if_c.din_signed = s; if_c.din_valid = v; if_c.dout_ready = r; end
    endcase
  endtask

  // One sample through an idle pipe: checks acceptance, 3-cycle latency and value.
  task automatic applyStimulus(input int sel, input logic [31:0] d, input logic s,
                               input logic [31:0] want, input string name);
    logic rdy;
    int   lat;
    act = sel;
    @(posedge clk); #1;
    set_in(d, s, 1'b1, 1'b1);
    @(negedge clk);
    rdy = o_dr;
    @(posedge clk); #1;
    set_in(d, s, 1'b0, 1'b1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!o_dv && lat < 10);
    checkOutput({name, " ready"}, {31'b0, rdy}, 32'd1);
    checkOutput({name, " latency"}, 32'(lat), 32'd3);
    checkOutput({name, " value"}, o_dout, want);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] cur_d, prev_dout;
    logic        cur_s, cur_v, prev_stall, stable_ok, stale;
    int          sent, recv, cyc, acc, first_out, last_out;

    vecs[0] = '{0, 32'h01, 1'b1, 32'h3F80_0000, "s8 one"};
    vecs[1] = '{0, 32'h80, 1'b1, 32'hC300_0000, "s8 min"};
    vecs[2] = '{0, 32'hFF, 1'b1, 32'hBF80_0000, "s8 minus one"};
    vecs[3] = '{0, 32'h00, 1'b1, 32'h0000_0000, "s8 zero"};
    vecs[4] = '{0, 32'hFF, 1'b0, 32'h437F_0000, "u8 255"};
    vecs[5] = '{1, 32'h18, 1'b1, 32'h3FC0_0000, "q4 1.5"};
    vecs[6] = '{2, 32'd16777217, 1'b0, 32'h4B80_0000, "u32 tie even"};
    vecs[7] = '{2, 32'd16777219, 1'b0, 32'h4B80_0002, "u32 tie up"};
    vecs[8] = '{2, 32'hFFFF_FFFF, 1'b0, 32'h4F80_0000, "u32 carry"};
    vecs[9] = '{2, 32'h8000_0000, 1'b1, 32'hCF00_0000, "s32 min"};

    for (int i = 0; i < 3; i++) begin
      act = i;
      set_in(32'h0, 1'b0, 1'b0, 1'b1);
    end

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    act = 0;
    @(negedge clk);
    checkOutput("reset dout_valid", {31'b0, o_dv}, 32'd0);
    checkOutput("reset dout", o_dout, 32'd0);
    checkOutput("reset din_ready", {31'b0, o_dr}, 32'd1);

    for (int i = 0; i < 10; i++)
      applyStimulus(vecs[i].sel, vecs[i].d, vecs[i].s, vecs[i].want, vecs[i].name);

    // Toggling consumer, random producer on the 32-bit instance.
    act = 2;
    sent = 0; recv = 0; cyc = 0;
    prev_stall = 1'b0; prev_dout = '0; stable_ok = 1'b1;
    cur_d = $urandom; cur_s = 1'($urandom_range(0, 1));
    while (recv < 10 && cyc < 400) begin
      @(posedge clk); #1;
      cur_v = (sent < 10) && ($urandom_range(0, 1) == 1);
      set_in(cur_d, cur_s, cur_v, (cyc % 2) == 0);
      @(negedge clk);
      if (prev_stall && o_dout !== prev_dout) stable_ok = 1'b0;
      if (o_dv && (cyc % 2) == 0) begin
        if (expq.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL bp extra: got %h expected none", o_dout);
        end else checkOutput("bp data", o_dout, expq.pop_front());
        recv++;
      end
      if (cur_v && o_dr) begin
        expq.push_back(model(cur_d, cur_s, 32, 0));
        sent++;
        cur_d = $urandom; cur_s = 1'($urandom_range(0, 1));
      end
      prev_stall = o_dv && (cyc % 2) != 0;
      prev_dout  = o_dout;
      cyc++;
    end
    checkOutput("bp count", 32'(recv), 32'd10);
    checkOutput("bp stable", {31'b0, stable_ok}, 32'd1);

    // Consumer blocked: exactly three samples fit before din_ready drops.
    acc = 0; cyc = 0;
    do begin
      @(posedge clk); #1;
      set_in(cur_d, cur_s, 1'b1, 1'b0);
      @(negedge clk);
      if (o_dr) begin
        acc++;
        expq.push_back(model(cur_d, cur_s, 32, 0));
        cur_d = $urandom; cur_s = 1'($urandom_range(0, 1));
      end
      cyc++;
    end while (o_dr && cyc < 20);
    checkOutput("fill count", 32'(acc), 32'd3);
    recv = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      set_in(cur_d, cur_s, 1'b0, 1'b1);
      @(negedge clk);
      if (o_dv && expq.size() > 0) begin
        checkOutput("drain data", o_dout, expq.pop_front());
        recv++;
      end
    end
    checkOutput("drain count", 32'(recv), 32'd3);

    // Full rate on the 8-bit instance.
    act = 0;
    expq.delete();
    acc = 0; recv = 0; first_out = -1; last_out = -1;
    cur_d = $urandom & 32'hFF; cur_s = 1'($urandom_range(0, 1));
    for (int c = 0; c < 110; c++) begin
      @(posedge clk); #1;
      set_in(cur_d, cur_s, c < 100, 1'b1);
      @(negedge clk);
      if (o_dv) begin
        if (first_out < 0) first_out = c;
        last_out = c;
        recv++;
        if (expq.size() > 0) checkOutput("rate data", o_dout, expq.pop_front());
      end
      if (c < 100 && o_dr) begin
        acc++;
        expq.push_back(model(cur_d, cur_s, 8, 0));
        cur_d = $urandom & 32'hFF; cur_s = 1'($urandom_range(0, 1));
      end
    end
    checkOutput("rate accepted", 32'(acc), 32'd100);
    checkOutput("rate results", 32'(recv), 32'd100);
    checkOutput("rate first", 32'(first_out), 32'd3);
    checkOutput("rate last", 32'(last_out), 32'd102);

    // Reset with three samples held in a stalled pipe.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      set_in(32'h10 + 32'(i), 1'b0, 1'b1, 1'b0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    set_in(32'h55, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    set_in(32'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("rst dout_valid", {31'b0, o_dv}, 32'd0);
    checkOutput("rst dout", o_dout, 32'd0);
    stale = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (o_dv) stale = 1'b1;
    end
    checkOutput("rst stale", {31'b0, stale}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
